// File: rtl/sumcheck_fj_sched_pkg.sv
// Shared field parameters, scheduler state encoding and the mod-F_Q add helper
// for the sumcheck F_j scheduler slice.
`timescale 1ns/1ps
package sumcheck_fj_sched_pkg;

    localparam int F_NBITS = 61;
    // Mersenne prime 2^61-1: every field element fits in F_NBITS bits.
    localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};

    typedef logic [F_NBITS-1:0] fe_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACCUM = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Both operands are already reduced, so one conditional subtract suffices.
    function automatic fe_t mod_add(input fe_t a, input fe_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) begin
            s = s - {1'b0, F_Q};
        end
        return s[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/sumcheck_fj_sched_field_mod_adder.sv
// Combinational a+b mod F_Q for one accumulation lane.
`timescale 1ns/1ps
module field_mod_adder
    import sumcheck_fj_sched_pkg::*;
(
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic [F_NBITS-1:0] s
);

    assign s = mod_add(a, b);

endmodule

// File: rtl/sumcheck_fj_sched.sv
// Round-robin scheduler sharing one F_j compute unit among NREQ gate requesters.
// Optional macro SUMCHECK_FJ_SCHED_COUNT_EN adds a saturating gate_count output.
`timescale 1ns/1ps
module sumcheck_fj_sched
    import sumcheck_fj_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                                 clk,
    input  logic                                 rstb,
    input  logic                                 start,
    input  logic                                 flush,
    input  logic [NREQ-1:0]                      req_valid,
    input  logic [NREQ-1:0][2:0][F_NBITS-1:0]    req_gatefn,
    input  logic [NREQ-1:0][2:0][F_NBITS-1:0]    req_addmul,
    output logic [NREQ-1:0]                      req_ack,
    output logic                                 unit_en,
    output logic [2:0][F_NBITS-1:0]              unit_gatefn,
    output logic [2:0][F_NBITS-1:0]              unit_addmul,
    input  logic                                 unit_ready_pulse,
    input  logic [2:0][F_NBITS-1:0]              unit_out,
    output logic [2:0][F_NBITS-1:0]              sum_out,
    output logic                                 busy,
    output logic                                 done_pulse,
`ifdef SUMCHECK_FJ_SCHED_COUNT_EN
    output logic [31:0]                          gate_count,
`endif
    output logic                                 ready
);

    localparam int PTR_W = $clog2(NREQ);

    state_t                     state_reg;
    state_t                     state_next;
    logic [PTR_W-1:0]           rr_ptr_reg;
    logic [PTR_W-1:0]           rr_ptr_next;
    logic [2:0][F_NBITS-1:0]    gatefn_reg;
    logic [2:0][F_NBITS-1:0]    addmul_reg;
    logic [2:0][F_NBITS-1:0]    uout_reg;
    logic [2:0][F_NBITS-1:0]    sum_reg;
    logic [2:0][F_NBITS-1:0]    sum_next;

    logic                       grant_found;
    logic [PTR_W-1:0]           grant_idx;

    // Rotating priority: scan from rr_ptr_reg upward, wrapping modulo NREQ.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_p       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx   = (int'(rr_ptr_reg) + i) % NREQ;
            idx_p = PTR_W'(idx);
            if (!grant_found && req_valid[idx_p]) begin
                grant_found = 1'b1;
                grant_idx   = idx_p;
            end
        end
    end

    assign rr_ptr_next = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            field_mod_adder u_add (
                .a (sum_reg[gi]),
                .b (uout_reg[gi]),
                .s (sum_next[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                if (grant_found) begin
                    state_next = ST_ISSUE;
                end else if (flush) begin
                    state_next = ST_DONE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (unit_ready_pulse) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: state_next = ST_ARB;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic; the ack is combinational so the requester sees it in the grant cycle.
    always_comb begin
        req_ack    = '0;
        unit_en    = 1'b0;
        busy       = 1'b0;
        done_pulse = 1'b0;
        ready      = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: ready = 1'b1;
            ST_ARB: begin
                busy = 1'b1;
                if (grant_found) begin
                    req_ack[grant_idx] = 1'b1;
                end else if (flush) begin
                    done_pulse = 1'b1;
                end
            end
            ST_ISSUE: begin
                busy    = 1'b1;
                unit_en = 1'b1;
            end
            ST_WAIT, ST_ACCUM: busy = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath: operand capture, unit result capture and accumulation.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rr_ptr_reg <= '0;
            gatefn_reg <= '0;
            addmul_reg <= '0;
            uout_reg   <= '0;
            sum_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sum_reg <= '0;
                    end
                end
                ST_ARB: begin
                    if (grant_found) begin
                        gatefn_reg <= req_gatefn[grant_idx];
                        addmul_reg <= req_addmul[grant_idx];
                        rr_ptr_reg <= rr_ptr_next;
                    end
                end
                ST_WAIT: begin
                    if (unit_ready_pulse) begin
                        uout_reg <= unit_out;
                    end
                end
                ST_ACCUM: sum_reg <= sum_next;
                default: ;
            endcase
        end
    end

`ifdef SUMCHECK_FJ_SCHED_COUNT_EN
    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count_reg <= '0;
        end else if ((state_reg == ST_IDLE || state_reg == ST_DONE) && start) begin
            count_reg <= '0;
        end else if (state_reg == ST_ACCUM && count_reg != 32'hFFFF_FFFF) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign gate_count = count_reg;
`endif

    assign unit_gatefn = gatefn_reg;
    assign unit_addmul = addmul_reg;
    assign sum_out     = sum_reg;

endmodule

// File: tb/tb_sumcheck_fj_sched.sv
// Directed self-checking bench for sumcheck_fj_sched with a multiplying stub unit.
`timescale 1ns/1ps
module tb_sumcheck_fj_sched;
    import sumcheck_fj_sched_pkg::*;

    localparam int NREQ = 4;

    logic                               clk = 1'b0;
    logic                               rstb;
    logic                               start;
    logic                               flush;
    logic [NREQ-1:0]                    req_valid;
    logic [NREQ-1:0][2:0][F_NBITS-1:0]  req_gatefn;
    logic [NREQ-1:0][2:0][F_NBITS-1:0]  req_addmul;
    logic [NREQ-1:0]                    req_ack;
    logic                               unit_en;
    logic [2:0][F_NBITS-1:0]            unit_gatefn;
    logic [2:0][F_NBITS-1:0]            unit_addmul;
    logic                               unit_ready_pulse;
    logic [2:0][F_NBITS-1:0]            unit_out;
    logic [2:0][F_NBITS-1:0]            sum_out;
    logic                               busy;
    logic                               done_pulse;
    logic                               ready;
`ifdef SUMCHECK_FJ_SCHED_COUNT_EN
    logic [31:0]                        gate_count;
`endif

    int checks   = 0;
    int failures = 0;
    int stub_lat = 3;
    int stub_cnt;
    int ack_cnt [NREQ];
    int done_cnt = 0;
    int ack_q [$];

    always #5 clk = ~clk;

    sumcheck_fj_sched #(.NREQ(NREQ)) dut (
        .clk              (clk),
        .rstb             (rstb),
        .start            (start),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_gatefn       (req_gatefn),
        .req_addmul       (req_addmul),
        .req_ack          (req_ack),
        .unit_en          (unit_en),
        .unit_gatefn      (unit_gatefn),
        .unit_addmul      (unit_addmul),
        .unit_ready_pulse (unit_ready_pulse),
        .unit_out         (unit_out),
        .sum_out          (sum_out),
        .busy             (busy),
        .done_pulse       (done_pulse),
`ifdef SUMCHECK_FJ_SCHED_COUNT_EN
        .gate_count       (gate_count),
`endif
        .ready            (ready)
    );

    function automatic fe_t mulmod(input fe_t a, input fe_t b);
        logic [2*F_NBITS-1:0] p;
        p = (2*F_NBITS)'(a) * (2*F_NBITS)'(b);
        return fe_t'(p % (2*F_NBITS)'(F_Q));
    endfunction

    // Stub compute unit: products mod F_Q, result pulse stub_lat+1 cycles after unit_en.
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stub_cnt         <= 0;
            unit_ready_pulse <= 1'b0;
            unit_out         <= '0;
        end else begin
            unit_ready_pulse <= 1'b0;
            if (unit_en) begin
                stub_cnt <= stub_lat;
                for (int k = 0; k < 3; k++) begin
                    unit_out[k] <= mulmod(unit_gatefn[k], unit_addmul[k]);
                end
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    unit_ready_pulse <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_ack[i]) begin
                ack_cnt[i] = ack_cnt[i] + 1;
                ack_q.push_back(i);
                $display("[%0t] ack req=%0d gatefn0=%0d addmul0=%0d", $time, i,
                         req_gatefn[i][0], req_addmul[i][0]);
            end
        end
        if (done_pulse) begin
            done_cnt = done_cnt + 1;
            $display("[%0t] round done sum={%0d,%0d,%0d}", $time,
                     sum_out[0], sum_out[1], sum_out[2]);
        end
    end

    task automatic clear_counters();
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
        done_cnt = 0;
        ack_q.delete();
    endtask

    task automatic apply_reset();
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Present one gate on requester idx and hold it until acked; returns just after the ack edge.
    task automatic present(input int idx, input fe_t g0, input fe_t g1, input fe_t g2,
                           input fe_t a0, input fe_t a1, input fe_t a2, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        req_gatefn[idx][0] = g0; req_gatefn[idx][1] = g1; req_gatefn[idx][2] = g2;
        req_addmul[idx][0] = a0; req_addmul[idx][1] = a1; req_addmul[idx][2] = a2;
        req_valid[idx] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ack[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1 req_valid[idx] = 1'b0;
    endtask

    task automatic finish_round(output bit ok);
        ok = 1'b0;
        flush = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_pulse) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstb = 1'b0; start = 1'b0; flush = 1'b0;
        req_valid = '0; req_gatefn = '0; req_addmul = '0;
        #12;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags ready=%b busy=%b done=%b required 1 0 0", ready, busy, done_pulse);
        end
        checks++;
        if (req_ack !== '0 || unit_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack ack=%b unit_en=%b required 0 0", req_ack, unit_en);
        end
        checks++;
        if (sum_out !== '0 || unit_gatefn !== '0 || unit_addmul !== '0) begin
            failures++;
            $display("FAIL reset_regs sum0=%0d gatefn0=%0d required 0", sum_out[0], unit_gatefn[0]);
        end
        @(posedge clk); #1 rstb = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_gate();
        bit ok;
        fe_t exp_s [3];
        exp_s = '{fe_t'(10), fe_t'(18), fe_t'(28)};
        clear_counters();
        stub_lat = 3;
        do_start();
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL single_started busy=%b ready=%b required 1 0", busy, ready);
        end
        present(0, 2, 3, 4, 5, 6, 7, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_ack_timeout got=0 required=1");
        end
        finish_round(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_done_timeout got=0 required=1");
        end
        repeat (4) @(negedge clk);
        checks++;
        if (ack_cnt[0] != 1 || ack_cnt[1] != 0 || ack_cnt[2] != 0 || ack_cnt[3] != 0) begin
            failures++;
            $display("FAIL single_ack_count got=%0d,%0d,%0d,%0d required 1,0,0,0",
                     ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sum_out[k] !== exp_s[k]) begin
                failures++;
                $display("FAIL single_sum lane=%0d got=%0d required=%0d", k, sum_out[k], exp_s[k]);
            end
        end
        checks++;
        if (done_cnt != 1 || ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done done_cnt=%0d ready=%b busy=%b required 1 1 0", done_cnt, ready, busy);
        end
`ifdef SUMCHECK_FJ_SCHED_COUNT_EN
        checks++;
        if (gate_count !== 32'd1) begin
            failures++;
            $display("FAIL single_count got=%0d required=1", gate_count);
        end
`endif
    endtask

    task automatic test_wrap();
        bit ok1, ok2, okd;
        fe_t qm1, qm2;
        qm1 = F_Q - fe_t'(1);
        qm2 = F_Q - fe_t'(2);
        clear_counters();
        stub_lat = 2;
        do_start();
        present(2, qm1, qm1, 1, 1, 1, qm1, ok1);
        present(3, qm1, qm1, 1, 1, 1, qm1, ok2);
        finish_round(okd);
        checks++;
        if (!(ok1 && ok2 && okd)) begin
            failures++;
            $display("FAIL wrap_handshake got=%b%b%b required=111", ok1, ok2, okd);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sum_out[k] !== qm2) begin
                failures++;
                $display("FAIL wrap_sum lane=%0d got=%0h required=%0h", k, sum_out[k], qm2);
            end
        end
    endtask

    task automatic test_fairness();
        bit okd;
        bit timed_out;
        apply_reset();
        clear_counters();
        stub_lat = 1;
        do_start();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 3; k++) begin
                req_gatefn[i][k] = fe_t'(i + 1);
                req_addmul[i][k] = fe_t'(1);
            end
        end
        req_valid = '1;
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ack_q.size() >= 8) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk); #1 req_valid = '0;
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL fair_timeout acks=%0d required=8", ack_q.size());
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (j >= ack_q.size() || ack_q[j] != (j % NREQ)) begin
                failures++;
                $display("FAIL fair_order slot=%0d got=%0d required=%0d", j,
                         (j < ack_q.size()) ? ack_q[j] : -1, j % NREQ);
            end
        end
        finish_round(okd);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sum_out[k] !== fe_t'(20)) begin
                failures++;
                $display("FAIL fair_sum lane=%0d got=%0d required=20", k, sum_out[k]);
            end
        end
`ifdef SUMCHECK_FJ_SCHED_COUNT_EN
        checks++;
        if (gate_count !== 32'd8) begin
            failures++;
            $display("FAIL fair_count got=%0d required=8", gate_count);
        end
`endif
    endtask

    task automatic test_flush_in_wait();
        bit ok;
        int gap;
        bit seen_en, seen_rdy, seen_done;
        clear_counters();
        stub_lat = 5;
        do_start();
        present(1, 3, 3, 3, 3, 3, 3, ok);
        seen_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (unit_en) begin
                seen_en = 1'b1;
                break;
            end
        end
        @(posedge clk); #1 flush = 1'b1;
        seen_rdy = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (unit_ready_pulse) begin
                seen_rdy = 1'b1;
                break;
            end
        end
        checks++;
        if (!(ok && seen_en && seen_rdy) || done_cnt != 0) begin
            failures++;
            $display("FAIL flush_pre_result ok=%b en=%b rdy=%b done_cnt=%0d required 1 1 1 0",
                     ok, seen_en, seen_rdy, done_cnt);
        end
        gap = 0;
        seen_done = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (done_pulse) begin
                gap = c;
                seen_done = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen_done || gap != 2) begin
            failures++;
            $display("FAIL flush_done_gap got=%0d required=2", gap);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sum_out[k] !== fe_t'(9)) begin
                failures++;
                $display("FAIL flush_sum lane=%0d got=%0d required=9", k, sum_out[k]);
            end
        end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_in_wait();
        bit ok1, ok2, okd;
        clear_counters();
        stub_lat = 3;
        do_start();
        present(0, 1, 1, 1, 4, 4, 4, ok1);
        present(2, 2, 2, 2, 3, 3, 3, ok2);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL start_wait_state busy=%b ready=%b required 1 0", busy, ready);
        end
        finish_round(okd);
        checks++;
        if (!(ok1 && ok2 && okd)) begin
            failures++;
            $display("FAIL start_wait_handshake got=%b%b%b required=111", ok1, ok2, okd);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sum_out[k] !== fe_t'(10)) begin
                failures++;
                $display("FAIL start_wait_sum lane=%0d got=%0d required=10", k, sum_out[k]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok1, ok2, ok3, okd;
        clear_counters();
        stub_lat = 6;
        do_start();
        present(1, 5, 5, 5, 5, 5, 5, ok1);
        present(3, 7, 7, 7, 8, 8, 8, ok2);
        @(posedge clk); #1 rstb = 1'b0;
        #1;
        checks++;
        if (sum_out !== '0 || ready !== 1'b1 || busy !== 1'b0 || unit_gatefn !== '0) begin
            failures++;
            $display("FAIL midreset_state sum0=%0d ready=%b busy=%b gatefn0=%0d required 0 1 0 0",
                     sum_out[0], ready, busy, unit_gatefn[0]);
        end
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        clear_counters();
        stub_lat = 2;
        do_start();
        present(2, 1, 1, 1, 9, 9, 9, ok3);
        finish_round(okd);
        checks++;
        if (!(ok1 && ok2 && ok3 && okd) || ack_cnt[2] != 1 || done_cnt != 1) begin
            failures++;
            $display("FAIL midreset_handshake ok=%b%b%b%b ack2=%0d done=%0d required 1111 1 1",
                     ok1, ok2, ok3, okd, ack_cnt[2], done_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sum_out[k] !== fe_t'(9)) begin
                failures++;
                $display("FAIL midreset_sum lane=%0d got=%0d required=9", k, sum_out[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_gate();
        test_wrap();
        test_fairness();
        test_flush_in_wait();
        test_start_in_wait();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
